// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencer (load-use stalls, branch flushes, wait-stated data memory, timeout halt)
//   clk, rst_n                 clock / async active-low reset
//   rs1_id, rs2_id, use_rs*    decode-stage source operands
//   memread_ex, rd_ex          EX-stage load and its destination
//   memop_mem, taken_mem       MEM-stage memory op / taken branch
//   dmem_ready, dmem_req       data memory handshake
//   pcwrite..mwwrite           pipeline register enables
//   fdflush, deflush, exflush  pipeline register bubble controls
//   mem_err, halted            sticky timeout flag / HALT state
//   stall_cnt, flush_cnt       saturating event counters
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   input  logic             use_rs1,
   input  logic             use_rs2,
   input  logic             memread_ex,
   input  logic [4:0]       rd_ex,
   input  logic             memop_mem,
   input  logic             taken_mem,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pcwrite,
   output logic             fdwrite,
   output logic             dewrite,
   output logic             exwrite,
   output logic             mwwrite,
   output logic             fdflush,
   output logic             deflush,
   output logic             exflush,
   output logic             mem_err,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;
   state_t state, state_nx;
   logic [WW-1:0] wcnt, wcnt_nx;
   logic lu, go, br, bub, err_nx;
   always_comb begin
      lu = memread_ex & (rd_ex != 5'd0) & ((use_rs1 & (rs1_id == rd_ex)) | (use_rs2 & (rs2_id == rd_ex)));
      // go: the pipeline may advance this cycle (no outstanding memory wait)
      go = (state == RUN) ? !(memop_mem & !dmem_ready) : (state == MEMWAIT) & dmem_ready;
      br = go & taken_mem;
      bub = go & !taken_mem & lu;
      pcwrite = rst_n & go & !bub;
      fdwrite = rst_n & go & !bub;
      dewrite = rst_n & go;
      exwrite = rst_n & go;
      mwwrite = rst_n & go;
      fdflush = !rst_n | br;
      deflush = !rst_n | br | bub;
      exflush = !rst_n | br;
      dmem_req = rst_n & ((memop_mem & (state != HALT)) | (state == MEMWAIT));
      halted = rst_n & (state == HALT);
      state_nx = state;
      wcnt_nx = wcnt;
      err_nx = mem_err;
      if (state == RUN && memop_mem && !dmem_ready) begin
         state_nx = MEMWAIT;
         wcnt_nx = WW'(1);
      end else if (state == MEMWAIT) begin
         if (dmem_ready) state_nx = RUN;
         else if (wcnt == WW'(MEM_TIMEOUT)) begin
            state_nx = HALT;
            err_nx = 1'b1;
         end else wcnt_nx = wcnt + WW'(1);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         wcnt <= '0;
         mem_err <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nx;
         wcnt <= wcnt_nx;
         mem_err <= err_nx;
         if (state != HALT && !pcwrite && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
         if (br && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
endmodule
